pixel_group_scheduler: RTL

//  Two-level scheduler for an event-camera pixel array, superseding the combinational group-grant tree.
//  - Tiles a ROWS x COLS request array into GRP_ROWS x GRP_COLS groups and locks one group at a time.
//  - Serves every pending pixel in the locked group, one per transaction.
//  - Emits each served pixel's address over a valid/ready event port.
//  - Releases the group and moves on. Sits between the pixel array and the event FIFO/readout.

---
 rtl/pixel_group_scheduler_pkg.sv | 14 +
 rtl/pixel_group_scheduler_if.sv | 35 +++
 rtl/pixel_group_scheduler_rr_arbiter.sv | 48 ++++
 rtl/pixel_group_scheduler.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pixel_group_scheduler_pkg.sv
// Shared scheduler types: FSM state encoding and arbitration mode constants.
package lib_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SEND    = 2'd2,
    RELEASE = 2'd3
  } sched_state_e;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/pixel_group_scheduler_if.sv
// Event-port bundle between pixel array, scheduler and event FIFO.
// EBC_TIMESTAMP_EN adds the evt_ts_o field and its TS_W parameter.
interface pixel_group_scheduler_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16
`ifdef EBC_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
);
  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [ROWS-1:0][COLS-1:0] req_i;
  logic                      evt_ready_i;
  logic [ROWS-1:0][COLS-1:0] gnt_o;
  logic                      evt_valid_o;
  logic [XW-1:0]             evt_x_o;
  logic [YW-1:0]             evt_y_o;
  logic                      active_o;
  logic                      grp_release_o;
`ifdef EBC_TIMESTAMP_EN
  logic [TS_W-1:0]           evt_ts_o;

  modport master (output req_i, evt_ready_i,
                  input  gnt_o, evt_valid_o, evt_x_o, evt_y_o, evt_ts_o, active_o, grp_release_o);
  modport slave  (input  req_i, evt_ready_i,
                  output gnt_o, evt_valid_o, evt_x_o, evt_y_o, evt_ts_o, active_o, grp_release_o);
`else
  modport master (output req_i, evt_ready_i,
                  input  gnt_o, evt_valid_o, evt_x_o, evt_y_o, active_o, grp_release_o);
  modport slave  (input  req_i, evt_ready_i,
                  output gnt_o, evt_valid_o, evt_x_o, evt_y_o, active_o, grp_release_o);
`endif

endinterface

// File: rtl/pixel_group_scheduler_rr_arbiter.sv
// N-way arbiter: round-robin from a registered pointer, or fixed lowest-index priority.
// The pointer moves past the granted index on i_adv; i_clr forces it back to 0.
module rr_arbiter
  import lib_arbiter_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int PRIO_MODE = PRIO_RR,
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  input  logic          i_clr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_pos;
  logic          w_found;

  always_comb begin
    w_found = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = (PRIO_MODE == PRIO_FIXED) ? IW'(k) : IW'((int'(r_ptr) + k) % N);
      if (!w_found && i_req[w_pos]) begin
        w_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

  assign o_gnt = w_found ? (N'(1) << o_idx) : '0;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_adv && w_found) begin
      r_ptr <= (int'(o_idx) == N - 1) ? '0 : o_idx + IW'(1);
    end
  end

endmodule

// File: rtl/pixel_group_scheduler.sv
// Two-level event-camera scheduler: locks one pixel group, drains its requests, releases it.
// Define EBC_TIMESTAMP_EN to add a free-running timestamp sampled per event.
module pixel_group_scheduler
  import lib_arbiter_pkg::*;
#(
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int GRP_ROWS  = 2,
  parameter int GRP_COLS  = 2,
  parameter int PRIO_MODE = PRIO_RR
`ifdef EBC_TIMESTAMP_EN
  , parameter int TS_W    = 16
`endif
) (
  input logic                    clk_i,
  input logic                    reset_i,
  pixel_group_scheduler_if.slave bus
);

  localparam int GX = COLS / GRP_COLS;
  localparam int NG = (ROWS / GRP_ROWS) * GX;
  localparam int NP = GRP_ROWS * GRP_COLS;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;

  sched_state_e              r_state;
  logic [GW-1:0]             r_grp;
  logic [ROWS-1:0][COLS-1:0] r_gnt;
  logic                      r_valid;
  logic [XW-1:0]             r_x;
  logic [YW-1:0]             r_y;

  logic [NG-1:0] w_grp_req, w_grp_gnt;
  logic [GW-1:0] w_grp_idx;
  logic [NP-1:0] w_pix_req, w_pix_gnt;
  logic [PW-1:0] w_pix_idx;
  logic [XW-1:0] w_px;
  logic [YW-1:0] w_py;
  logic          w_lock, w_pick, w_hs;

  always_comb begin
    w_grp_req = '0;
    w_pix_req = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (bus.req_i[r][c]) w_grp_req[(r / GRP_ROWS) * GX + c / GRP_COLS] = 1'b1;
        if ((r / GRP_ROWS) * GX + c / GRP_COLS == int'(r_grp))
          w_pix_req[(r % GRP_ROWS) * GRP_COLS + c % GRP_COLS] = bus.req_i[r][c];
      end
    end
  end

  assign w_px   = XW'((int'(r_grp) % GX) * GRP_COLS + int'(w_pix_idx) % GRP_COLS);
  assign w_py   = YW'((int'(r_grp) / GX) * GRP_ROWS + int'(w_pix_idx) / GRP_COLS);
  assign w_lock = (r_state == IDLE) && (|w_grp_gnt);
  assign w_pick = (r_state == LOAD) && (|w_pix_gnt);
  assign w_hs   = (r_state == SEND) && r_valid && bus.evt_ready_i;

  // Pointers step at selection time; equivalent to stepping at release/handshake
  // because the selected index is fixed until then and reset clears both anyway.
  rr_arbiter #(.N(NG), .PRIO_MODE(PRIO_MODE)) u_grp_arb (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .i_req  (w_grp_req),
    .i_adv  (w_lock),
    .i_clr  (1'b0),
    .o_gnt  (w_grp_gnt),
    .o_idx  (w_grp_idx)
  );

  rr_arbiter #(.N(NP), .PRIO_MODE(PRIO_MODE)) u_pix_arb (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .i_req  (w_pix_req),
    .i_adv  (w_pick),
    .i_clr  (w_lock),
    .o_gnt  (w_pix_gnt),
    .o_idx  (w_pix_idx)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_grp   <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_lock) begin
            r_grp   <= w_grp_idx;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (w_pick) begin
            r_gnt           <= '0;
            r_gnt[w_py][w_px] <= 1'b1;
            r_x             <= w_px;
            r_y             <= w_py;
            r_valid         <= 1'b1;
            r_state         <= SEND;
          end else begin
            r_state <= RELEASE;
          end
        end
        SEND: begin
          if (w_hs) begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_state <= LOAD;
          end
        end
        RELEASE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef EBC_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts_cnt, r_ts;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_ts_cnt <= '0;
      r_ts     <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + TS_W'(1);
      if (w_pick) r_ts <= r_ts_cnt;
    end
  end

  assign bus.evt_ts_o = r_ts;
`endif

  assign bus.gnt_o         = r_gnt;
  assign bus.evt_valid_o   = r_valid;
  assign bus.evt_x_o       = r_x;
  assign bus.evt_y_o       = r_y;
  assign bus.active_o      = (r_state != IDLE);
  assign bus.grp_release_o = (r_state == RELEASE);

endmodule
